// File: rtl/rmi_pkg.sv
// Shared types and defaults for the RMI schedule bank controller.
package rmi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_SWAP,
        SWAP
    } rmiState_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DEPTH  = 16;

endpackage

// File: rtl/rmi_edge_det.sv
// Rising-edge detector: rise is high in the first cycle sigIn is sampled high.
module rmi_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sigIn,
    output logic rise
);

    logic sigD;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sigD <= 1'b0;
        end else begin
            sigD <= sigIn;
        end
    end

    assign rise = sigIn & ~sigD;

endmodule

// File: rtl/rmi_bank_ctrl.sv
// Ping-pong schedule bank controller: fills the shadow BRAM word by word and
// flips selMem only once a complete schedule is in place.
module rmi_bank_ctrl
    import rmi_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DEPTH         = DEF_DEPTH,
    parameter int SWAP_ON_FRAME = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx,
    input  logic [DATA_W-1:0] newSchedule,
    input  logic              wordValid,
    output logic              wordReady,
    input  logic              frameStart,
    output logic              wrEn1,
    output logic [ADDR_W-1:0] wrAdd1,
    output logic [DATA_W-1:0] wrData1,
    output logic              wrEn2,
    output logic [ADDR_W-1:0] wrAdd2,
    output logic [DATA_W-1:0] wrData2,
    output logic              selMem,
    output logic              busy,
    output logic              done,
    output logic              drop
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    rmiState_e        state;
    rmiState_e        stateNext;
    logic [CNT_W-1:0] count;
    logic             txRise;
    logic             accept;
    logic             lastWord;

    rmi_edge_det txEdge (
        .clk  (clk),
        .rst  (rst),
        .sigIn(tx),
        .rise (txRise)
    );

    assign wordReady = (state == LOAD);
    assign accept    = wordValid & wordReady;
    assign lastWord  = (count == CNT_W'(DEPTH - 1));
    assign busy      = (state != IDLE);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:      if (txRise) stateNext = LOAD;
            LOAD:      if (accept && lastWord) stateNext = WAIT_SWAP;
            WAIT_SWAP: if (frameStart || (SWAP_ON_FRAME == 0)) stateNext = SWAP;
            SWAP:      stateNext = IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // count is the index of the next word to accept, so it doubles as the write address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (state == IDLE) begin
            count <= '0;
        end else if (accept) begin
            count <= count + 1'b1;
        end
    end

    // Shadow bank is ~selMem: selMem=0 means BRAM2 is the one being written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrEn1   <= 1'b0;
            wrAdd1  <= '0;
            wrData1 <= '0;
            wrEn2   <= 1'b0;
            wrAdd2  <= '0;
            wrData2 <= '0;
        end else begin
            wrEn1 <= accept & selMem;
            wrEn2 <= accept & ~selMem;
            if (accept && selMem) begin
                wrAdd1  <= ADDR_W'(count);
                wrData1 <= newSchedule;
            end
            if (accept && !selMem) begin
                wrAdd2  <= ADDR_W'(count);
                wrData2 <= newSchedule;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            selMem <= 1'b0;
            done   <= 1'b0;
            drop   <= 1'b0;
        end else begin
            done <= (state == SWAP);
            drop <= txRise & (state != IDLE);
            if (state == SWAP) begin
                selMem <= ~selMem;
            end
        end
    end

endmodule
